// File: rtl/spike_axis_unpack_if.sv
// Bundle of the H2C AXI-Stream slave side and the presynaptic spike side of spike_axis_unpack.
// slave = the unpacker, master = whoever drives the stream and consumes the packs.
interface spike_axis_unpack_if #(
  parameter int PACK_WIDTH      = 8,
  parameter int AXIS_DATA_WIDTH = 32
);
  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic                       s_axis_tlast;
  logic [KEEP_W-1:0]          s_axis_tkeep;
  logic                       o_spike_valid;
  logic [PACK_WIDTH-1:0]      o_spike_data;
  logic                       i_spike_ready;
  logic                       o_spike_last;
  logic                       o_frame_done;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tkeep, i_spike_ready,
    output s_axis_tready, o_spike_valid, o_spike_data, o_spike_last, o_frame_done
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tkeep, i_spike_ready,
    input  s_axis_tready, o_spike_valid, o_spike_data, o_spike_last, o_frame_done
  );
endinterface

// File: rtl/spike_axis_unpack.sv
// Unpacks H2C AXIS words into PACK_WIDTH spike packs, lowest lane first, carrying tlast framing.
// Optional SPIKE_UNPACK_STATS_EN adds pack/frame/partial-keep counters.
module spike_axis_unpack #(
  parameter int PACK_WIDTH      = 8,
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spike_axis_unpack_if.slave   bus
`ifdef SPIKE_UNPACK_STATS_EN
  ,
  output logic [31:0]          o_pack_count,
  output logic [31:0]          o_frame_count,
  output logic [31:0]          o_keep_err_count
`endif
);
  localparam int LANES = AXIS_DATA_WIDTH / PACK_WIDTH;
  localparam int BPL   = PACK_WIDTH / 8;

  logic [LANES-1:0][PACK_WIDTH-1:0] data_q, data_d;
  logic [LANES-1:0]                 mask_q, mask_d;
  logic                             last_q, last_d;
  logic                             full_q, full_d;
  logic                             fd_q, fd_d;

  logic [LANES-1:0]  lane_full, lane_part, sel_oh;
  logic [PACK_WIDTH-1:0] sel_data;
  logic              one_left, spike_valid, hs, retire_now, tready, accept;

  // A lane survives only with every byte kept; "partial" means some but not all bytes.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_full[k] = &bus.s_axis_tkeep[k*BPL +: BPL];
    assign lane_part[k] = (|bus.s_axis_tkeep[k*BPL +: BPL]) & ~lane_full[k];
  end

  assign sel_oh      = mask_q & (~mask_q + LANES'(1));
  assign one_left    = (mask_q != '0) && ((mask_q & (mask_q - LANES'(1))) == '0);
  assign spike_valid = full_q & (|mask_q);
  assign hs          = spike_valid & bus.i_spike_ready;
  assign retire_now  = (full_q & ~(|mask_q)) | (hs & one_left);
  assign tready      = rst_n & (~full_q | retire_now);
  assign accept      = bus.s_axis_tvalid & tready;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < LANES; k++)
      if (sel_oh[k]) sel_data = sel_data | data_q[k];
  end

  assign bus.s_axis_tready = tready;
  assign bus.o_spike_valid = spike_valid;
  assign bus.o_spike_data  = spike_valid ? sel_data : '0;
  assign bus.o_spike_last  = spike_valid & last_q & one_left;
  assign bus.o_frame_done  = fd_q;

  // Accept has priority over retire so a retiring word hands over without a bubble.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    last_d = last_q;
    full_d = full_q;
    fd_d   = retire_now & last_q;
    if (accept) begin
      data_d = bus.s_axis_tdata;
      mask_d = lane_full;
      last_d = bus.s_axis_tlast;
      full_d = 1'b1;
    end else if (retire_now) begin
      mask_d = '0;
      full_d = 1'b0;
    end else if (hs) begin
      mask_d = mask_q & ~sel_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      full_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      last_q <= last_d;
      full_q <= full_d;
      fd_q   <= fd_d;
    end
  end

`ifdef SPIKE_UNPACK_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_pack_count     <= '0;
      o_frame_count    <= '0;
      o_keep_err_count <= '0;
    end else begin
      if (hs)                    o_pack_count     <= o_pack_count + 32'd1;
      if (fd_q)                  o_frame_count    <= o_frame_count + 32'd1;
      if (accept && |lane_part)  o_keep_err_count <= o_keep_err_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_spike_axis_unpack.sv
// Scoreboard bench for spike_axis_unpack: 8-bit pack DUT for streaming scenarios, 16-bit pack DUT for lane masking.
module tb_spike_axis_unpack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_axis_unpack_if #(.PACK_WIDTH(8),  .AXIS_DATA_WIDTH(32)) bus();
  spike_axis_unpack_if #(.PACK_WIDTH(16), .AXIS_DATA_WIDTH(32)) bus16();

`ifdef SPIKE_UNPACK_STATS_EN
  logic [31:0] pc, fc, kc, pc16, fc16, kc16;
`endif

  spike_axis_unpack #(.PACK_WIDTH(8), .AXIS_DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef SPIKE_UNPACK_STATS_EN
    , .o_pack_count(pc), .o_frame_count(fc), .o_keep_err_count(kc)
`endif
  );

  spike_axis_unpack #(.PACK_WIDTH(16), .AXIS_DATA_WIDTH(32)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16)
`ifdef SPIKE_UNPACK_STATS_EN
    , .o_pack_count(pc16), .o_frame_count(fc16), .o_keep_err_count(kc16)
`endif
  );

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t q[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   fd_cnt = 0;
  int   fd_cyc = -1;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every pack handshake, tracks frame_done pulses.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.o_frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (bus.o_spike_valid && bus.i_spike_ready) begin
      hs_cyc.push_back(cyc);
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pack: got data=%h last=%b, expected no pack", bus.o_spike_data, bus.o_spike_last);
      end else begin
        e = q.pop_front();
        if ({bus.o_spike_data, bus.o_spike_last} !== {e.d, e.l}) begin
          n_err++;
          $display("FAIL pack: got data=%h last=%b, expected data=%h last=%b",
                   bus.o_spike_data, bus.o_spike_last, e.d, e.l);
        end
      end
    end else if (!bus.o_spike_valid) begin
      n_cmp++;
      if (bus.o_spike_data !== 8'h00) begin
        n_err++;
        $display("FAIL idle_data: got %h while valid=0, expected 00", bus.o_spike_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int acc);
    int hi;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.s_axis_tready) begin
        step();
        acc = cyc;
        break;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    if (acc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: tready never high for word %h, expected accept within 200 cycles", d);
    end else begin
      hi = -1;
      for (int i = 0; i < 4; i++) if (k[i]) hi = i;
      for (int i = 0; i < 4; i++)
        if (k[i]) q.push_back('{d: d[i*8 +: 8], l: (l && i == hi)});
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d packs outstanding, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'h5A5A5A5A; bus.s_axis_tkeep = 4'hF;
    bus.s_axis_tlast = 1'b1; bus.i_spike_ready = 1'b1;
    bus16.s_axis_tvalid = 1'b0; bus16.s_axis_tdata = '0; bus16.s_axis_tkeep = '0;
    bus16.s_axis_tlast = 1'b0; bus16.i_spike_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if ({bus.s_axis_tready, bus.o_spike_valid, bus.o_spike_data, bus.o_spike_last, bus.o_frame_done} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h last=%b fd=%b, expected all 0",
               bus.s_axis_tready, bus.o_spike_valid, bus.o_spike_data, bus.o_spike_last, bus.o_frame_done);
    end
    n_cmp++;
    if ({bus16.s_axis_tready, bus16.o_spike_valid, bus16.o_spike_data} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_outputs16: got rdy=%b vld=%b data=%h, expected all 0",
               bus16.s_axis_tready, bus16.o_spike_valid, bus16.o_spike_data);
    end
    bus.s_axis_tvalid = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b, expected 1", bus.s_axis_tready);
    end
    step();
  endtask

  task automatic test_full_keep();
    int acc, h0, f0;
    h0 = hs_cyc.size(); f0 = fd_cnt;
    bus.i_spike_ready = 1'b1;
    send(32'hDDCCBBAA, 4'hF, 1'b1, acc);
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if (bus.s_axis_tready !== 1'b1 || bus.o_spike_data !== 8'hDD) begin
      n_err++;
      $display("FAIL full_last_cycle: got rdy=%b data=%h, expected rdy=1 data=dd", bus.s_axis_tready, bus.o_spike_data);
    end
    repeat (2) step();
    drain("full");
    n_cmp++;
    if (hs_cyc.size() - h0 != 4) begin
      n_err++;
      $display("FAIL full_count: got %0d packs, expected 4", hs_cyc.size() - h0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (hs_cyc[h0+i] != acc + i) begin
          n_err++;
          $display("FAIL full_timing: pack %0d at cycle %0d, expected %0d", i, hs_cyc[h0+i], acc + i);
        end
      end
    end
    n_cmp++;
    if (fd_cnt - f0 != 1 || fd_cyc != acc + 4) begin
      n_err++;
      $display("FAIL full_frame_done: got %0d pulses at cycle %0d, expected 1 at %0d", fd_cnt - f0, fd_cyc, acc + 4);
    end
  endtask

  task automatic test_sparse_keep();
    int acc, h0, f0;
    h0 = hs_cyc.size(); f0 = fd_cnt;
    send(32'h44332211, 4'h5, 1'b1, acc);
    repeat (4) step();
    drain("sparse");
    n_cmp++;
    if (hs_cyc.size() - h0 != 2 || hs_cyc[h0] != acc || hs_cyc[h0+1] != acc + 1) begin
      n_err++;
      $display("FAIL sparse_timing: got %0d packs, expected 2 at cycles %0d,%0d", hs_cyc.size() - h0, acc, acc + 1);
    end
    n_cmp++;
    if (fd_cnt - f0 != 1 || fd_cyc != acc + 2) begin
      n_err++;
      $display("FAIL sparse_frame_done: got %0d pulses at cycle %0d, expected 1 at %0d", fd_cnt - f0, fd_cyc, acc + 2);
    end
  endtask

  task automatic test_empty_word();
    int acc, h0, f0;
    h0 = hs_cyc.size(); f0 = fd_cnt;
    send(32'hCAFEF00D, 4'h0, 1'b1, acc);
    @(negedge clk);
    n_cmp++;
    if (bus.o_spike_valid !== 1'b0 || bus.s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL empty_hold: got vld=%b rdy=%b, expected vld=0 rdy=1", bus.o_spike_valid, bus.s_axis_tready);
    end
    repeat (3) step();
    n_cmp++;
    if (hs_cyc.size() != h0 || fd_cnt - f0 != 1 || fd_cyc != acc + 1) begin
      n_err++;
      $display("FAIL empty_frame_done: got packs=%0d pulses=%0d at cycle %0d, expected packs=0 pulses=1 at %0d",
               hs_cyc.size() - h0, fd_cnt - f0, fd_cyc, acc + 1);
    end
  endtask

  task automatic test_backpressure();
    int acc, h0;
    h0 = hs_cyc.size();
    bus.i_spike_ready = 1'b1;
    send(32'h04030201, 4'hF, 1'b0, acc);
    step();
    bus.i_spike_ready = 1'b0;
    bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = 32'hFFEEDDCC; bus.s_axis_tkeep = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_spike_valid, bus.o_spike_data, bus.o_spike_last, bus.s_axis_tready} !== {1'b1, 8'h02, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got vld=%b data=%h last=%b rdy=%b, expected vld=1 data=02 last=0 rdy=0",
                 i, bus.o_spike_valid, bus.o_spike_data, bus.o_spike_last, bus.s_axis_tready);
      end
      step();
    end
    bus.s_axis_tvalid = 1'b0;
    bus.i_spike_ready = 1'b1;
    drain("bp");
    step();
    n_cmp++;
    if (hs_cyc.size() - h0 != 4) begin
      n_err++;
      $display("FAIL bp_count: got %0d packs, expected 4", hs_cyc.size() - h0);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, h0, gaps;
    h0 = hs_cyc.size();
    bus.i_spike_ready = 1'b1;
    send(32'h13121110, 4'hF, 1'b0, a0);
    send(32'h23222120, 4'hF, 1'b0, a1);
    send(32'h33323130, 4'hF, 1'b1, a2);
    drain("b2b");
    repeat (2) step();
    n_cmp++;
    if (hs_cyc.size() - h0 != 12) begin
      n_err++;
      $display("FAIL b2b_count: got %0d packs, expected 12", hs_cyc.size() - h0);
    end else begin
      gaps = 0;
      for (int i = 0; i < 12; i++) if (hs_cyc[h0+i] != a0 + i) gaps++;
      n_cmp++;
      if (gaps != 0) begin
        n_err++;
        $display("FAIL b2b_gaps: got %0d off-cycle packs, expected 0 (first at %0d, expected %0d)", gaps, hs_cyc[h0], a0);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int acc, acc2, h0;
    bus.i_spike_ready = 1'b1;
    send(32'h0D0C0B0A, 4'hF, 1'b1, acc);
    repeat (2) step();
    rst_n = 1'b0;
    bus.i_spike_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.s_axis_tready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_gate_ready: got %b, expected 0", bus.s_axis_tready);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.o_spike_valid !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_word: got vld=%b rdy=%b, expected 0 0", bus.o_spike_valid, bus.s_axis_tready);
    end
    q.delete();
    step();
    rst_n = 1'b1;
    bus.i_spike_ready = 1'b1;
    h0 = hs_cyc.size();
    send(32'h1D1C1B1A, 4'hF, 1'b1, acc2);
    drain("rst");
    repeat (2) step();
    n_cmp++;
    if (hs_cyc.size() - h0 != 4 || hs_cyc[h0] != acc2) begin
      n_err++;
      $display("FAIL rst_resume: got %0d packs, expected 4 starting at cycle %0d", hs_cyc.size() - h0, acc2);
    end
`ifdef SPIKE_UNPACK_STATS_EN
    n_cmp++;
    if ({pc, fc, kc} !== {32'd4, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL stats8: got pack=%0d frame=%0d keep_err=%0d, expected 4 1 0", pc, fc, kc);
    end
`endif
  endtask

  task automatic test_pack16();
    bus16.i_spike_ready = 1'b1;
    bus16.s_axis_tdata = 32'h87654321; bus16.s_axis_tkeep = 4'h7;
    bus16.s_axis_tlast = 1'b1; bus16.s_axis_tvalid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus16.s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL p16_ready: got %b, expected 1", bus16.s_axis_tready);
    end
    step();
    bus16.s_axis_tvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus16.o_spike_valid, bus16.o_spike_data, bus16.o_spike_last} !== {1'b1, 16'h4321, 1'b1}) begin
      n_err++;
      $display("FAIL p16_pack: got vld=%b data=%h last=%b, expected vld=1 data=4321 last=1",
               bus16.o_spike_valid, bus16.o_spike_data, bus16.o_spike_last);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus16.o_spike_valid !== 1'b0 || bus16.o_frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL p16_done: got vld=%b fd=%b, expected vld=0 fd=1", bus16.o_spike_valid, bus16.o_frame_done);
    end
    step();
`ifdef SPIKE_UNPACK_STATS_EN
    @(negedge clk);
    n_cmp++;
    if ({pc16, fc16, kc16} !== {32'd1, 32'd1, 32'd1}) begin
      n_err++;
      $display("FAIL p16_stats: got pack=%0d frame=%0d keep_err=%0d, expected 1 1 1", pc16, fc16, kc16);
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_full_keep();
    test_sparse_keep();
    test_empty_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_pack16();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
